// File: rtl/spike_rx_interface_if.sv
// Router-to-neuron receive bundle: flit write path plus the published spike outputs.
// master = router/neuron-core side, slave = spike_rx_interface.
interface spike_rx_interface_if #(
    parameter int FLIT_SIZE = 4,
    parameter int NUM_AXONS = 256
);
    logic                 write_en;
    logic [FLIT_SIZE-1:0] data_in;
    logic                 neuron_full;
    logic                 start;
    logic                 hold;
    logic [NUM_AXONS-1:0] spike;
    logic                 spike_valid;
    logic                 err_addr;
    logic [15:0]          drop_cnt;

    modport master (
        output write_en, data_in, start, hold,
        input  neuron_full, spike, spike_valid, err_addr, drop_cnt
    );

    modport slave (
        input  write_en, data_in, start, hold,
        output neuron_full, spike, spike_valid, err_addr, drop_cnt
    );
endinterface

// File: rtl/spike_rx_interface.sv
// Neuron-side receive path: flit reassembly, destination check, axon-index FIFO,
// per-timestep axon accumulator published as the spike vector on each start pulse.
module spike_rx_interface #(
    parameter int PACKET_SIZE        = 32,
    parameter int FLIT_SIZE          = 4,
    parameter int X_ADDR_LEN         = 8,
    parameter int Y_ADDR_LEN         = 8,
    parameter int X_ID               = 1,
    parameter int Y_ID               = 1,
    parameter int CHECK_DEST         = 1,
    parameter int NUM_AXONS          = 256,
    parameter int AXON_CNT_BIT_WIDTH = 8,
    parameter int FIFO_DEPTH         = 4
) (
    input logic                 clk,
    input logic                 reset,
    spike_rx_interface_if.slave rx_if
);
    localparam int FLITS = PACKET_SIZE / FLIT_SIZE;
    localparam int CW    = (FLITS > 1) ? $clog2(FLITS) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int A     = AXON_CNT_BIT_WIDTH;

    localparam logic [CW-1:0]         LAST_FLIT = CW'(FLITS - 1);
    localparam logic [PW+1:0]         DEPTH_C   = FIFO_DEPTH[PW+1:0];
    localparam logic [31:0]           NUM_AX_U  = NUM_AXONS;
    localparam logic [X_ADDR_LEN-1:0] MY_X      = X_ID[X_ADDR_LEN-1:0];
    localparam logic [Y_ADDR_LEN-1:0] MY_Y      = Y_ID[Y_ADDR_LEN-1:0];

    if (PACKET_SIZE % FLIT_SIZE != 0) begin : g_bad_flit
        $error("spike_rx_interface: PACKET_SIZE must be a multiple of FLIT_SIZE");
    end
    if (X_ADDR_LEN + Y_ADDR_LEN + A > PACKET_SIZE) begin : g_bad_fields
        $error("spike_rx_interface: address and axon fields overlap");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spike_rx_interface: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    logic [CW-1:0]          flit_cnt_q, flit_cnt_d;
    logic [PACKET_SIZE-1:0] shreg_q, shreg_d;
    logic [X_ADDR_LEN-1:0]  dest_x_q, dest_x_d;
    logic [Y_ADDR_LEN-1:0]  dest_y_q, dest_y_d;
    logic [A-1:0]           idx_q, idx_d;
    logic                   pkt_valid_q, pkt_valid_d;
    logic [A-1:0]           mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic [NUM_AXONS-1:0]   accum_q, accum_d;
    logic [NUM_AXONS-1:0]   spike_q, spike_d;
    logic                   spike_valid_q, spike_valid_d;
    logic                   err_addr_q, err_addr_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic flit_acc, last_flit, addr_bad, range_bad, push, pop, drop, full;

    // Full counts the packet sitting in decode, so every decoded packet has a FIFO slot.
    assign full      = ({1'b0, count_q} + {{(PW + 1){1'b0}}, pkt_valid_q}) >= DEPTH_C;
    assign flit_acc  = rx_if.write_en && !full;
    assign last_flit = flit_cnt_q == LAST_FLIT;
    assign shreg_d   = (shreg_q << FLIT_SIZE) | PACKET_SIZE'(rx_if.data_in);

    assign addr_bad  = (CHECK_DEST != 0) && ((dest_x_q != MY_X) || (dest_y_q != MY_Y));
    assign range_bad = 32'(idx_q) >= NUM_AX_U;
    assign push      = pkt_valid_q && !addr_bad && !range_bad;
    assign drop      = pkt_valid_q && (addr_bad || range_bad);
    assign pop       = (count_q != '0) && !rx_if.hold && !rx_if.start;

    always_comb begin
        flit_cnt_d    = flit_cnt_q;
        dest_x_d      = dest_x_q;
        dest_y_d      = dest_y_q;
        idx_d         = idx_q;
        pkt_valid_d   = 1'b0;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        accum_d       = accum_q;
        spike_d       = spike_q;
        spike_valid_d = rx_if.start;
        err_addr_d    = pkt_valid_q && addr_bad;
        drop_cnt_d    = drop_cnt_q;

        if (flit_acc) begin
            flit_cnt_d = last_flit ? '0 : flit_cnt_q + 1'b1;
            if (last_flit) begin
                pkt_valid_d = 1'b1;
                dest_x_d    = shreg_d[PACKET_SIZE-1 -: X_ADDR_LEN];
                dest_y_d    = shreg_d[PACKET_SIZE-X_ADDR_LEN-1 -: Y_ADDR_LEN];
                idx_d       = shreg_d[A-1:0];
            end
        end

        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (rx_if.start) begin
            spike_d = accum_q;
            accum_d = '0;
        end else if (pop) begin
            accum_d[mem_q[rd_ptr_q]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_cnt_q    <= '0;
            shreg_q       <= '0;
            dest_x_q      <= '0;
            dest_y_q      <= '0;
            idx_q         <= '0;
            pkt_valid_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            accum_q       <= '0;
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            err_addr_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            flit_cnt_q    <= flit_cnt_d;
            if (flit_acc) begin
                shreg_q <= shreg_d;
            end
            dest_x_q      <= dest_x_d;
            dest_y_q      <= dest_y_d;
            idx_q         <= idx_d;
            pkt_valid_q   <= pkt_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            accum_q       <= accum_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
            err_addr_q    <= err_addr_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= idx_q;
        end
    end

    assign rx_if.neuron_full = full;
    assign rx_if.spike       = spike_q;
    assign rx_if.spike_valid = spike_valid_q;
    assign rx_if.err_addr    = err_addr_q;
    assign rx_if.drop_cnt    = drop_cnt_q;
endmodule
